// File: rtl/mem_arbiter.sv
// Shares the single-port MIX core memory between N requesters with a req/ack handshake and an optional exclusive lock.
// Fixed priority by default; define ROUND_ROBIN_EN for rotating priority.
module mem_arbiter #(
   parameter int N       = 3,
   parameter int AW      = 12,
   parameter int DW      = 31,
   parameter int MEMSIZE = 4000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N-1:0]    req,
   input  logic [N-1:0]    we,
   input  logic [N*AW-1:0] addr,
   input  logic [N*DW-1:0] wdata,
   input  logic [N-1:0]    lock,
   output logic [N-1:0]    ack,
   output logic [N-1:0]    err,
   output logic [N-1:0]    rvalid,
   output logic [DW-1:0]   rdata,
   output logic            mem_en,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   input  logic [DW-1:0]   mem_rdata
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [AW:0] MEM_LIMIT = (AW + 1)'(MEMSIZE);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t         state_q, state_d;
   logic [IW-1:0]  owner_q, owner_d;
`ifdef ROUND_ROBIN_EN
   logic [IW-1:0]  ptr_q, ptr_d;
   int             rr_idx;
`endif

   logic [N-1:0]   elig;
   logic           gnt_vld;
   logic [IW-1:0]  gnt_idx;
   logic [AW-1:0]  gnt_addr;
   logic [DW-1:0]  gnt_wdata;
   logic           gnt_oor;

   logic [N-1:0]   ack_q, ack_d, err_q, err_d;
   logic [N-1:0]   rd_pend_q, rd_pend_d, rvalid_q;
   logic           mem_en_q, mem_en_d, mem_we_q, mem_we_d;
   logic [AW-1:0]  mem_addr_q, mem_addr_d;
   logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
   logic [DW-1:0]  rdata_hold_q;

   // State register: FSM state plus every registered output.
   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= '0;
`ifdef ROUND_ROBIN_EN
         ptr_q        <= '0;
`endif
         ack_q        <= '0;
         err_q        <= '0;
         rd_pend_q    <= '0;
         rvalid_q     <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         rdata_hold_q <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
`ifdef ROUND_ROBIN_EN
         ptr_q        <= ptr_d;
`endif
         ack_q        <= ack_d;
         err_q        <= err_d;
         rd_pend_q    <= rd_pend_d;
         rvalid_q     <= rd_pend_q;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         rdata_hold_q <= rdata;
      end
   end

   // Arbitration and next state. A requester being acked this cycle is still holding its old request.
   // NOTE: every variable gets a default first so no path through the block infers a latch.
   always_comb begin
      elig    = '0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      state_d = state_q;
      owner_d = owner_q;
`ifdef ROUND_ROBIN_EN
      ptr_d   = ptr_q;
      rr_idx  = 0;
`endif
      if (state_q == LOCKED) elig[owner_q] = req[owner_q] & ~ack_q[owner_q];
      else                   elig = req & ~ack_q;

`ifdef ROUND_ROBIN_EN
      for (int k = N - 1; k >= 0; k--) begin
         rr_idx = int'(ptr_q) + k;
         if (rr_idx >= N) rr_idx = rr_idx - N;
         if (elig[rr_idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = IW'(rr_idx);
         end
      end
`else
      for (int k = N - 1; k >= 0; k--) begin
         if (elig[k]) begin
            gnt_vld = 1'b1;
            gnt_idx = IW'(k);
         end
      end
`endif

      if (state_q == IDLE) begin
         if (gnt_vld) begin
            if (lock[gnt_idx]) begin
               state_d = LOCKED;
               owner_d = gnt_idx;
            end
`ifdef ROUND_ROBIN_EN
            ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
`endif
         end
      end else begin
         if ((gnt_vld && !lock[owner_q]) || (!gnt_vld && !req[owner_q] && !lock[owner_q])) begin
            state_d = IDLE;
            owner_d = '0;
         end
      end
   end

   // Next values of the registered outputs for the winning requester.
   always_comb begin
      gnt_addr    = addr[gnt_idx*AW +: AW];
      gnt_wdata   = wdata[gnt_idx*DW +: DW];
      gnt_oor     = ({1'b0, gnt_addr} >= MEM_LIMIT);
      ack_d       = '0;
      err_d       = '0;
      rd_pend_d   = '0;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      if (gnt_vld) begin
         ack_d[gnt_idx] = 1'b1;
         if (gnt_oor) begin
            err_d[gnt_idx] = 1'b1;
         end else begin
            mem_en_d   = 1'b1;
            mem_addr_d = gnt_addr;
            if (we[gnt_idx]) begin
               mem_we_d    = 1'b1;
               mem_wdata_d = gnt_wdata;
            end else begin
               rd_pend_d[gnt_idx] = 1'b1;
            end
         end
      end
   end

   // The RAM's registered output arrives together with rvalid, so it is steered straight through and held afterwards.
   assign rdata     = (|rvalid_q) ? mem_rdata : rdata_hold_q;
   assign ack       = ack_q;
   assign err       = err_q;
   assign rvalid    = rvalid_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule
